lsu_controller: RTL and testbench
=================================

LSU_CONTROLLER -- requirements
Module: lsu_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus-timeout limit in cycles, used only when LSU_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have these ports from the EX/MEM stage:
- mem_read  input  1  load request
- mem_write  input  1  store request
- func3  input  3  size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
- addr  input  32  byte address
- wdata  input  32  store data, in the low bits
- flush  input  1  suppress a new request
REQ-005 SHALL have these Wishbone-classic data-bus ports:
- wb_cyc  output  1
- wb_stb  output  1
- wb_we  output  1
- wb_sel  output  4
- wb_adr  output  32, word-aligned
- wb_dat_o  output  32
- wb_dat_i  input  32
- wb_ack  input  1
REQ-006 SHALL have these pipeline-side ports:
- stall  output  1  freeze the pipeline
- load_data  output  32  extended load result
- misaligned  output  1  one-cycle alignment exception
- bus_err  output  1  one-cycle timeout exception

Function
REQ-007 SHALL implement the FSM states IDLE, REQ and DONE.
REQ-008 In IDLE, with (mem_read|mem_write) & ~flush & aligned, SHALL register the bus outputs and enter REQ at the next edge.
REQ-009 Alignment rules:
- halfword: addr[0]=0
- word: addr[1:0]=0
- byte: always aligned
REQ-010 A misaligned request in IDLE SHALL pulse misaligned for that cycle (combinational), issue no bus cycle, keep stall low, and stay in IDLE.
REQ-011 In REQ, wb_cyc and wb_stb SHALL be 1 and all bus outputs SHALL hold stable until wb_ack.
REQ-012 On wb_ack in REQ, SHALL register wb_dat_i for loads, deassert wb_cyc/wb_stb at the next edge, and enter DONE.
REQ-013 DONE SHALL last exactly one cycle, with stall=0 and load_data valid, then return to IDLE.
REQ-014 stall SHALL be 1 in IDLE when an aligned request is pending and not flushed, and 1 in REQ; it SHALL be 0 otherwise.
REQ-015 Minimum load/store latency SHALL be 3 cycles (IDLE, REQ with ack, DONE); each extra wait state SHALL add 1 cycle.
REQ-016 wb_sel SHALL be:
- byte: 4'b0001<<addr[1:0]
- half: 4'b0011<<addr[1:0]
- word: 4'hF
REQ-017 wb_dat_o SHALL replicate the store byte/half across all lanes, and wb_adr SHALL be {addr[31:2],2'b00}.
REQ-018 load_data SHALL select the lane given by the latched addr[1:0] and func3; it SHALL sign-extend for LB/LH and zero-extend for LBU/LHU.
REQ-019 Simultaneous mem_read and mem_write SHALL be treated as a store.
REQ-020 flush SHALL act only in IDLE; a transaction already in REQ SHALL run to ack.
REQ-021 wb_ack outside REQ SHALL be ignored.

Reset
REQ-022 On reset the FSM SHALL go to IDLE at the next edge, aborting REQ (cyc/stb low next cycle).
REQ-023 On reset, all outputs and registers SHALL be 0.

Configuration
REQ-024 With LSU_TIMEOUT_EN defined, a counter SHALL clear on REQ entry and increment each REQ cycle without ack.
REQ-025 Timeout action: when the counter reaches TIMEOUT_CYCLES, SHALL drop cyc/stb, pulse bus_err during DONE, leave load_data at 0, and enter DONE.
REQ-026 Without LSU_TIMEOUT_EN, no counter SHALL exist, bus_err SHALL be tied to 0, and REQ SHALL wait indefinitely.

Structure
REQ-027 The func3 size encodings and the FSM state enum (lsu_state_t) SHALL live in shared package riscv_pkg.
REQ-028 Lane selection and extension SHALL be in the combinational sub-module load_align, instantiated once.

Verification
REQ-029 Bench SHALL cover:
- LW addr=0x100, ack after 2 waits, dat_i=0xDEADBEEF -> wb_sel=F, wb_adr=0x100, stall 4 cycles, load_data=0xDEADBEEF in DONE.
- LB addr=0x103, dat_i=0x80FFFFFF -> wb_sel=1000, load_data=0xFFFFFF80; LBU -> 0x00000080.
- SH addr=0x202, wdata=0x1234 -> wb_we=1, wb_sel=1100, wb_dat_o=0x12341234.
- LW addr=0x101 -> misaligned=1 for one cycle, wb_cyc stays 0, stall=0.
- reset asserted mid-REQ -> wb_cyc=0 next cycle, state IDLE, stray ack ignored.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no ack -> bus_err pulses after 8 REQ cycles, stall releases.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the load/store unit: func3 size/sign encodings, the
// access-size enum, the LSU FSM state enum and small helper functions for
// alignment and Wishbone byte-lane selection.
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_pkg;

   // func3 encodings for loads and stores. func3[1:0] is the access size,
   // func3[2] marks a zero-extending load.
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } lsu_state_t;

   // Any size code other than byte/half is handled as a word access.
   function automatic mem_size_t f3_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return SIZE_BYTE;
         2'b01:   return SIZE_HALF;
         default: return SIZE_WORD;
      endcase
   endfunction

   function automatic logic is_aligned(input mem_size_t size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: return 1'b1;
         SIZE_HALF: return ~off[0];
         default:   return (off == 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] lane_sel(input mem_size_t size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: return 4'b0001 << off;
         SIZE_HALF: return 4'b0011 << off;
         default:   return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load-data formatter: picks the addressed byte/halfword lane
// out of the captured bus word and sign- or zero-extends it to 32 bits.
// Ports:
//   data    in  32  word as returned by the bus
//   offset  in  2   byte offset of the access (addr[1:0])
//   func3   in  3   load size/sign encoding
//   result  out 32  extended load value
// ---------------------------------------------------------------------------
module load_align
   import riscv_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  offset,
   input  logic [2:0]  func3,
   output logic [31:0] result
);

   logic [31:0] shifted;
   logic        sign;

   always_comb begin
      // Move the addressed lane down to bit 0 first; extension then only
      // ever looks at the low byte/halfword.
      shifted = data >> {offset, 3'b000};
      sign    = 1'b0;
      result  = data;
      case (f3_size(func3))
         SIZE_BYTE: begin
            sign   = ~func3[2] & shifted[7];
            result = {{24{sign}}, shifted[7:0]};
         end
         SIZE_HALF: begin
            sign   = ~func3[2] & shifted[15];
            result = {{16{sign}}, shifted[15:0]};
         end
         default: result = data;
      endcase
   end

endmodule

// File: rtl/lsu_controller.sv
// ---------------------------------------------------------------------------
// lsu_controller
// Load/store unit bridging the EX/MEM stage to a Wishbone-classic data bus.
// One transaction at a time: IDLE -> REQ (bus cycle open) -> DONE -> IDLE.
//
// Optional feature: define LSU_TIMEOUT_EN to enable a bus timeout. REQ then
// gives up after TIMEOUT_CYCLES cycles without wb_ack and reports bus_err.
// Without the macro REQ waits indefinitely and bus_err is constant 0.
//
// Handshake: a request is accepted in IDLE when (mem_read|mem_write) is
// high, flush is low and the address is aligned; stall stays high from that
// IDLE cycle through every REQ cycle. The bus cycle is open while
// wb_cyc&wb_stb; it completes in the cycle wb_ack is high (wb_ack is ignored
// in any other state). DONE is a single cycle with stall low and load_data
// valid.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   mem_read/mem_write  load/store request (both high = store)
//   func3, addr, wdata  size/sign, byte address, store data (low bits)
//   flush               suppresses a new request in IDLE
//   wb_*                Wishbone-classic master signals
//   stall               freeze the pipeline
//   load_data           extended load result (valid in DONE)
//   misaligned          combinational alignment exception pulse
//   bus_err             timeout exception pulse during DONE
//   state               current FSM state (debug)
// ---------------------------------------------------------------------------
module lsu_controller
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  func3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        flush,
   output logic        wb_cyc,
   output logic        wb_stb,
   output logic        wb_we,
   output logic [3:0]  wb_sel,
   output logic [31:0] wb_adr,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        bus_err,
   output lsu_state_t  state
);

   lsu_state_t  state_next;
   mem_size_t   req_size;
   logic        req_valid;
   logic        req_aligned;
   logic        issue;
   logic        timed_out;
   logic [31:0] store_data;
   logic [31:0] rdata;
   logic [1:0]  lat_off;
   logic [2:0]  lat_f3;

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   assign req_size    = f3_size(func3);
   assign req_aligned = is_aligned(req_size, addr[1:0]);
   assign req_valid   = (mem_read | mem_write) & ~flush;
   assign issue       = (state == IDLE) & req_valid & req_aligned;

   // Both pulses are gated by reset so every output reads 0 while it is held.
   assign misaligned = ~reset & (state == IDLE) & req_valid & ~req_aligned;
   assign stall      = ~reset & (issue | (state == REQ));

   // Replicate the store lane across the whole word so the slave can take
   // it from whichever lane wb_sel enables.
   always_comb begin
      store_data = wdata;
      case (req_size)
         SIZE_BYTE: store_data = {4{wdata[7:0]}};
         SIZE_HALF: store_data = {2{wdata[15:0]}};
         default:   store_data = wdata;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (issue) state_next = REQ;
         REQ:     if (wb_ack || timed_out) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Bus outputs and load capture
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_cyc   <= 1'b0;
         wb_stb   <= 1'b0;
         wb_we    <= 1'b0;
         wb_sel   <= 4'b0000;
         wb_adr   <= 32'h0;
         wb_dat_o <= 32'h0;
         rdata    <= 32'h0;
         lat_off  <= 2'b00;
         lat_f3   <= 3'b000;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  wb_cyc   <= 1'b1;
                  wb_stb   <= 1'b1;
                  wb_we    <= mem_write;
                  wb_sel   <= lane_sel(req_size, addr[1:0]);
                  wb_adr   <= {addr[31:2], 2'b00};
                  wb_dat_o <= mem_write ? store_data : 32'h0;
                  lat_off  <= addr[1:0];
                  lat_f3   <= func3;
                  // Cleared here so a store or a timed-out load reads 0.
                  rdata    <= 32'h0;
               end
            end
            REQ: begin
               if (wb_ack) begin
                  wb_cyc <= 1'b0;
                  wb_stb <= 1'b0;
                  if (!wb_we) rdata <= wb_dat_i;
               end else if (timed_out) begin
                  wb_cyc <= 1'b0;
                  wb_stb <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   load_align u_load_align (
      .data   (rdata),
      .offset (lat_off),
      .func3  (lat_f3),
      .result (load_data)
   );

   // ------------------------------------------------------------------
   // Optional bus timeout
   // ------------------------------------------------------------------
`ifdef LSU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wait_cnt;
   logic [CW-1:0] wait_cnt_next;

   assign wait_cnt_next = wait_cnt + CW'(1);
   // Fires in the REQ cycle that would bring the count to TIMEOUT_CYCLES,
   // so REQ lasts exactly TIMEOUT_CYCLES cycles when no ack arrives.
   assign timed_out = (state == REQ) && !wb_ack && (wait_cnt_next == CW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
         bus_err  <= 1'b0;
      end else begin
         bus_err <= timed_out;
         if (issue)                         wait_cnt <= '0;
         else if (state == REQ && !wb_ack)  wait_cnt <= wait_cnt_next;
      end
   end
`else
   assign timed_out = 1'b0;
   // The timeout limit has no effect in this build; bus_err is constant 0.
   assign bus_err   = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_lsu_controller.sv
// ---------------------------------------------------------------------------
// tb_lsu_controller
// Directed plus randomized bench for lsu_controller. Expected bus signals
// and load results come from an arithmetic reference model; expected load
// results are queued at issue and popped in DONE.
// ---------------------------------------------------------------------------
module tb_lsu_controller;
   import riscv_pkg::*;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read, mem_write, flush;
   logic [2:0]  func3;
   logic [31:0] addr, wdata;
   logic        wb_cyc, wb_stb, wb_we;
   logic [3:0]  wb_sel;
   logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
   logic        wb_ack;
   logic        stall, misaligned, bus_err;
   logic [31:0] load_data;
   lsu_state_t  state;

   always #5 clk = ~clk;

   lsu_controller #(.TIMEOUT_CYCLES(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .func3      (func3),
      .addr       (addr),
      .wdata      (wdata),
      .flush      (flush),
      .wb_cyc     (wb_cyc),
      .wb_stb     (wb_stb),
      .wb_we      (wb_we),
      .wb_sel     (wb_sel),
      .wb_adr     (wb_adr),
      .wb_dat_o   (wb_dat_o),
      .wb_dat_i   (wb_dat_i),
      .wb_ack     (wb_ack),
      .stall      (stall),
      .load_data  (load_data),
      .misaligned (misaligned),
      .bus_err    (bus_err),
      .state      (state)
   );

   // ---------------- scoreboard ----------------
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_load = 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int size_bytes(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [31:0] a);
      int n = size_bytes(f3);
      return 4'(((1 << n) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_store(input logic [2:0] f3, input logic [31:0] w);
      int n = size_bytes(f3);
      if (n == 1) return {24'h0, w[7:0]} * 32'h0101_0101;
      if (n == 2) return {16'h0, w[15:0]} * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] d);
      int n = size_bytes(f3);
      logic [31:0] v;
      logic [31:0] span;
      if (n == 4) return d;
      span = 32'h1 << (8 * n);
      v = (d >> (8 * (a % 4))) % span;
      if (!f3[2] && v >= span / 2) v = v - span;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic release_req();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      flush     = 1'b0;
   endtask

   // One complete pipeline request, checked cycle by cycle. Entered and left
   // mid-cycle while the FSM is in IDLE.
   task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input int waits,
                      input logic [31:0] dat, input logic fl);
      logic active;
      logic ok;
      int   stalls;
      active = (rd | wr) & ~fl;
      ok     = active && ((a % size_bytes(f3)) == 0);
      stalls = 0;
      mem_read = rd; mem_write = wr; func3 = f3; addr = a; wdata = wd; flush = fl;
      wb_ack = 1'b0;
      #1;
      check("idle_state", state, IDLE);
      check("idle_stall", stall, ok);
      check("idle_misaligned", misaligned, active & ~ok);
      check("idle_cyc", wb_cyc, 0);
      if (stall) stalls++;
      if (!ok) begin
         step();
         release_req();
         #1;
         check("skip_state", state, IDLE);
         check("skip_cyc", wb_cyc, 0);
         check("skip_misaligned", misaligned, 0);
         return;
      end
      exp_q.push_back(wr ? 32'h0 : m_load(f3, a, dat));
      for (int w = 0; w <= waits; w++) begin
         step();
         wb_ack   = (w == waits);
         wb_dat_i = (w == waits) ? dat : $urandom;
         #1;
         check("req_state", state, REQ);
         check("req_cyc", wb_cyc, 1);
         check("req_stb", wb_stb, 1);
         check("req_we", wb_we, wr);
         check("req_sel", wb_sel, m_sel(f3, a));
         check("req_adr", wb_adr, a - (a % 4));
         if (wr) check("req_dat_o", wb_dat_o, m_store(f3, wd));
         check("req_stall", stall, 1);
         if (stall) stalls++;
      end
      step();
      wb_ack   = 1'b0;
      wb_dat_i = $urandom;
      #1;
      last_load = exp_q.pop_front();
      check("done_state", state, DONE);
      check("done_cyc", wb_cyc, 0);
      check("done_stb", wb_stb, 0);
      check("done_stall", stall, 0);
      check("done_bus_err", bus_err, 0);
      check("done_load_data", load_data, last_load);
      check("stall_cycles", stalls, waits + 2);
      step();
      release_req();
      #1;
      check("back_idle", state, IDLE);
      check("back_stall", stall, 0);
   endtask

   // ---------------- stimulus ----------------
   logic [2:0] ld_f3 [5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
   logic [2:0] st_f3 [3] = '{F3_SB, F3_SH, F3_SW};

   initial begin
      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
      func3 = 3'b000; addr = 32'h0; wdata = 32'h0; wb_dat_i = 32'h0; wb_ack = 1'b0;
      step();
      step();
      #1;
      check("rst_state", state, IDLE);
      check("rst_cyc", wb_cyc, 0);
      check("rst_stb", wb_stb, 0);
      check("rst_we", wb_we, 0);
      check("rst_sel", wb_sel, 0);
      check("rst_adr", wb_adr, 0);
      check("rst_dat_o", wb_dat_o, 0);
      check("rst_stall", stall, 0);
      check("rst_load_data", load_data, 0);
      check("rst_misaligned", misaligned, 0);
      check("rst_bus_err", bus_err, 0);
      reset = 1'b0;
      step();

      // Directed cases.
      txn(1, 0, F3_LW,  32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF, 0);
      check("lw_result", last_load, 32'hDEAD_BEEF);
      txn(1, 0, F3_LB,  32'h0000_0103, 32'h0, 0, 32'h80FF_FFFF, 0);
      check("lb_result", load_data, 32'hFFFF_FF80);
      txn(1, 0, F3_LBU, 32'h0000_0103, 32'h0, 1, 32'h80FF_FFFF, 0);
      check("lbu_result", load_data, 32'h0000_0080);
      txn(1, 0, F3_LH,  32'h0000_0042, 32'h0, 0, 32'h9ABC_1234, 0);
      txn(1, 0, F3_LHU, 32'h0000_0042, 32'h0, 0, 32'h9ABC_1234, 0);
      txn(0, 1, F3_SH,  32'h0000_0202, 32'h0000_1234, 1, 32'h0, 0);
      txn(0, 1, F3_SB,  32'h0000_0301, 32'h0000_00A5, 0, 32'h0, 0);
      txn(1, 1, F3_SW,  32'h0000_0400, 32'hCAFE_F00D, 0, 32'h1111_1111, 0);
      txn(1, 0, F3_LW,  32'h0000_0101, 32'h0, 0, 32'h0, 0);
      txn(1, 0, F3_LH,  32'h0000_0103, 32'h0, 0, 32'h0, 0);
      txn(1, 0, F3_LW,  32'h0000_0010, 32'h0, 0, 32'h0, 1);

      // Stray ack in IDLE must change nothing.
      wb_ack = 1'b1;
      wb_dat_i = 32'h5555_AAAA;
      step();
      wb_ack = 1'b0;
      #1;
      check("stray_state", state, IDLE);
      check("stray_cyc", wb_cyc, 0);
      check("stray_load_data", load_data, last_load);

      // Reset in the middle of REQ aborts the cycle.
      mem_read = 1'b1; func3 = F3_LW; addr = 32'h0000_0300;
      step();
      #1;
      check("abort_req_cyc", wb_cyc, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      release_req();
      wb_ack = 1'b1;
      wb_dat_i = 32'h7777_7777;
      #1;
      check("abort_cyc", wb_cyc, 0);
      check("abort_state", state, IDLE);
      check("abort_load_data", load_data, 0);
      step();
      wb_ack = 1'b0;
      #1;
      check("abort_ack_state", state, IDLE);
      check("abort_ack_cyc", wb_cyc, 0);
      check("abort_ack_load", load_data, 0);

`ifdef LSU_TIMEOUT_EN
      begin
         int reqs;
         reqs = 0;
         mem_read = 1'b1; func3 = F3_LW; addr = 32'h0000_0040;
         for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #3;
            if (state == REQ) reqs++;
            else break;
         end
         check("to_state", state, DONE);
         check("to_req_cycles", reqs, 8);
         check("to_bus_err", bus_err, 1);
         check("to_load_data", load_data, 0);
         check("to_stall", stall, 0);
         check("to_cyc", wb_cyc, 0);
         step();
         release_req();
         #1;
         check("to_err_pulse", bus_err, 0);
         check("to_idle", state, IDLE);
      end
`endif

      // Randomized transactions.
      for (int t = 0; t < 40; t++) begin
         logic       wr, rd, fl;
         logic [2:0] f3;
         wr = 1'($urandom_range(0, 1));
         rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         f3 = wr ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
         fl = ($urandom_range(0, 7) == 0);
         txn(rd, wr, f3, $urandom, $urandom, $urandom_range(0, 3), $urandom, fl);
      end

      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
